// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(15,11)+parity SECDED encoder and decoder.
package hamming_pkg;

  localparam int CODE_W = 16;
  localparam int MSG_W  = 11;

  // Hamming positions holding data bits d1..d11 (msg[0]..msg[10]).
  localparam logic [3:0] DATA_POS [MSG_W] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

  // Coverage masks of the parity groups: every position whose index has
  // bit k set belongs to group p(2**k). Bit 0 (p0) is never part of a group.
  localparam logic [CODE_W-1:0] P1_MASK = 16'hAAAA;
  localparam logic [CODE_W-1:0] P2_MASK = 16'hCCCC;
  localparam logic [CODE_W-1:0] P4_MASK = 16'hF0F0;
  localparam logic [CODE_W-1:0] P8_MASK = 16'hFF00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENC   = 3'd1,
    WR_LO = 3'd2,
    WR_HI = 3'd3,
    DONE  = 3'd4
  } enc_state_t;

endpackage

// File: rtl/hamming16_enc.sv
// Combinational SECDED encoder: 11-bit message -> 16-bit codeword.
// Bits 1..15 are a Hamming(15,11) code, bit 0 is overall even parity.
module hamming16_enc
  import hamming_pkg::*;
(
  input  logic [MSG_W-1:0]  msg,
  output logic [CODE_W-1:0] code
);

  logic [CODE_W-1:0] data_word;
  logic [CODE_W-1:0] ham_word;

  // Scatter data bits to their non-power-of-two positions.
  always_comb begin
    data_word = '0;
    for (int i = 0; i < MSG_W; i++) begin
      data_word[DATA_POS[i]] = msg[i];
    end
  end

  // Parity positions are still zero in data_word, so each group XOR over
  // data_word yields the parity bit that makes that group even.
  always_comb begin
    ham_word    = data_word;
    ham_word[1] = ^(data_word & P1_MASK);
    ham_word[2] = ^(data_word & P2_MASK);
    ham_word[4] = ^(data_word & P4_MASK);
    ham_word[8] = ^(data_word & P8_MASK);
  end

  // p0 makes the full 16-bit word even.
  always_comb begin
    code    = ham_word;
    code[0] = ^ham_word[CODE_W-1:1];
  end

endmodule

// File: rtl/hamming_enc_writer.sv
// Encoder-side initiator: captures a message on start, encodes it to a
// 16-bit SECDED codeword and writes it as two bytes into consecutive
// register-file entries (low byte at dst_addr, high byte at dst_addr+1).
// The register-file write port has no handshake: a cycle with wr_en=1 is
// a completed write. start is a request sampled only in IDLE; there is no
// ready, and start while busy is simply dropped.
module hamming_enc_writer
  import hamming_pkg::*;
#(
  parameter int pw = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MSG_W-1:0]  msg,
  input  logic [pw-1:0]     dst_addr,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [pw-1:0]     wr_addr,
  output logic [7:0]        dat_out,
  output logic [CODE_W-1:0] code_out
);

  enc_state_t        state;
  logic [MSG_W-1:0]  msg_q;
  logic [pw-1:0]     addr_q;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_c;

  hamming16_enc u_enc (
    .msg  (msg_q),
    .code (code_c)
  );

  assign busy = (state != IDLE);

  // Sequencer: outputs are registered, so each transition loads the
  // outputs that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      msg_q    <= '0;
      addr_q   <= '0;
      code_q   <= '0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      dat_out  <= '0;
      code_out <= '0;
    end else begin
      done  <= 1'b0;
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            msg_q  <= msg;
            addr_q <= dst_addr;
            state  <= ENC;
          end
        end
        ENC: begin
          code_q  <= code_c;
          wr_en   <= 1'b1;
          wr_addr <= addr_q;
          dat_out <= code_c[7:0];
          state   <= WR_LO;
        end
        WR_LO: begin
          wr_en   <= 1'b1;
          wr_addr <= addr_q + 1'b1;
          dat_out <= code_q[15:8];
          state   <= WR_HI;
        end
        WR_HI: begin
          done     <= 1'b1;
          code_out <= code_q;
          state    <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_enc_writer.sv
// Directed bench for hamming_enc_writer with hand-computed codewords.
module tb_hamming_enc_writer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [10:0] msg;
  logic [3:0]  dst_addr;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  dat_out;
  logic [15:0] code_out;

  int n_cmp;
  int n_err;

  hamming_enc_writer #(.pw(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .msg      (msg),
    .dst_addr (dst_addr),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .dat_out  (dat_out),
    .code_out (code_out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction; start raised for cycle 0. With hold=1 start stays high
  // with a different message through cycles 1-4 and must be ignored.
  task automatic txn(input logic [10:0] m, input logic [3:0] a,
                     input logic [15:0] exp_code, input bit hold);
    logic [3:0] a_hi;
    int         n_wr;
    int         n_done;
    a_hi   = a + 4'd1;
    n_wr   = 0;
    n_done = 0;
    @(negedge clk);
    start    = 1'b1;
    msg      = m;
    dst_addr = a;
    check("idle_busy", busy, 0);
    // cycle 1: ENC
    @(negedge clk);
    if (hold) begin
      msg      = ~m;
      dst_addr = ~a;
    end else begin
      start = 1'b0;
    end
    check("enc_busy", busy, 1);
    check("enc_wr_en", wr_en, 0);
    n_wr   += int'(wr_en);
    n_done += int'(done);
    // cycle 2: WR_LO
    @(negedge clk);
    check("lo_wr_en", wr_en, 1);
    check("lo_addr", wr_addr, a);
    check("lo_data", dat_out, exp_code[7:0]);
    n_wr   += int'(wr_en);
    n_done += int'(done);
    // cycle 3: WR_HI
    @(negedge clk);
    check("hi_wr_en", wr_en, 1);
    check("hi_addr", wr_addr, a_hi);
    check("hi_data", dat_out, exp_code[15:8]);
    n_wr   += int'(wr_en);
    n_done += int'(done);
    // cycle 4: DONE
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_wr_en", wr_en, 0);
    check("code_out", code_out, exp_code);
    check("hold_addr", wr_addr, a_hi);
    n_wr   += int'(wr_en);
    n_done += int'(done);
    start = 1'b0;
    // cycle 5: back in IDLE
    @(negedge clk);
    check("idle_after_busy", busy, 0);
    check("idle_after_done", done, 0);
    check("idle_after_wr_en", wr_en, 0);
    n_wr   += int'(wr_en);
    n_done += int'(done);
    check("write_count", n_wr, 2);
    check("done_count", n_done, 1);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    msg      = '0;
    dst_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_dat_out", dat_out, 0);
    check("rst_code_out", code_out, 0);
    reset = 1'b0;

    txn(11'h000, 4'd4,  16'h0000, 1'b0);
    txn(11'h7FF, 4'd0,  16'hFFFF, 1'b0);
    txn(11'h001, 4'd2,  16'h000F, 1'b0);
    txn(11'h400, 4'd15, 16'h8117, 1'b0);
    // d2 at position 5 -> p1, p4, p0 set.
    txn(11'h002, 4'd7,  16'h0033, 1'b1);

    // Reset during WR_LO aborts the transaction.
    @(negedge clk);
    start    = 1'b1;
    msg      = 11'h7FF;
    dst_addr = 4'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_lo_wr_en", wr_en, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_dat_out", dat_out, 0);
    check("abort_code_out", code_out, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_quiet_wr_en", wr_en, 0);
      check("abort_quiet_done", done, 0);
    end

    txn(11'h001, 4'd2, 16'h000F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
